// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SAR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_REMU = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operations that run through the shift-add / restoring datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-step unsigned shift-add multiplier and restoring divider.
// The hi/lo register pair holds {product_hi, product_lo} when multiplying and
// {remainder, quotient} when dividing; the caller issues exactly WIDTH steps.
// A zero divisor needs no special case: every trial subtract succeeds, so the
// quotient fills with ones and the dividend bits shift into the remainder.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] hi, lo, b_q;
  logic             div_q;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   add_sum, shifted, trial;

  // Next value of the hi/lo pair for one multiply or divide iteration.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (div_q) begin
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Operand capture on load, one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= div_mode;
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

  assign product_hi = hi;
  assign product_lo = lo;
  assign quotient   = lo;
  assign remainder  = hi;

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with start/busy/done handshake.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start
//   ST_EXEC | operation in flight (busy=1); single-cycle ops spend one cycle
//           | here, iterative ops WIDTH steps plus one result-capture cycle
//   ST_DONE | done=1 for one cycle, busy=0, a new start is accepted here
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] s1_in,
  input  logic [WIDTH-1:0] s2_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SHW:0]     count;
  logic             iter_q;

  logic             accept, step, finish;
  logic [WIDTH-1:0] prod_hi, prod_lo, quot, rem;
  logic [WIDTH-1:0] res_c;
  logic [3:0]       flags_c;
  logic             c_c, v_c;
  logic [WIDTH:0]   sum, sh;
  logic [SHW-1:0]   amt;

  assign accept = start && (state != ST_EXEC);
  assign step   = (state == ST_EXEC) && iter_q && (count != CNT_LAST);
  assign finish = (state == ST_EXEC) && (!iter_q || (count == CNT_LAST));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (step),
    .div_mode   ((op_in == OP_DIVU) || (op_in == OP_REMU)),
    .a          (s1_in),
    .b          (s2_in),
    .product_hi (prod_hi),
    .product_lo (prod_lo),
    .quotient   (quot),
    .remainder  (rem)
  );

  // Result and flag values for the latched opcode; captured only on finish.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    sum   = '0;
    sh    = '0;
    amt   = b_q[SHW-1:0];
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res_c = sum[MSB:0];
        c_c   = sum[WIDTH];
        v_c   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sum   = {1'b0, a_q} - {1'b0, b_q};
        res_c = sum[MSB:0];
        c_c   = sum[WIDTH];
        v_c   = (a_q[MSB] != b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_INC: begin
        sum   = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
        res_c = sum[MSB:0];
        c_c   = sum[WIDTH];
        v_c   = (a_q == {1'b0, {MSB{1'b1}}});
      end
      OP_DEC: begin
        sum   = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
        res_c = sum[MSB:0];
        c_c   = sum[WIDTH];
        v_c   = (a_q == {1'b1, {MSB{1'b0}}});
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOT: res_c = ~a_q;
      // Extra bit beyond the operand catches the last bit shifted out.
      OP_SHL: begin
        sh    = {1'b0, a_q} << amt;
        res_c = sh[MSB:0];
        c_c   = sh[WIDTH];
      end
      OP_SHR: begin
        sh    = {a_q, 1'b0} >> amt;
        res_c = sh[WIDTH:1];
        c_c   = sh[0];
      end
      OP_SAR: begin
        sh    = $signed({a_q, 1'b0}) >>> amt;
        res_c = sh[WIDTH:1];
        c_c   = sh[0];
      end
      OP_MUL: begin
        res_c = prod_lo;
        c_c   = |prod_hi;
      end
      OP_DIVU: begin
        res_c = quot;
        v_c   = (b_q == '0);
      end
      OP_REMU: begin
        res_c = rem;
        v_c   = (b_q == '0);
      end
      default: res_c = '0;
    endcase
    flags_c         = '0;
    flags_c[FLAG_N] = res_c[MSB];
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_V] = v_c;
    flags_c[FLAG_C] = c_c;
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_out <= '0;
      flags      <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      count      <= '0;
      iter_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q   <= op_in;
            a_q    <= s1_in;
            b_q    <= s2_in;
            iter_q <= is_iterative(op_in);
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (finish) begin
            result_out <= res_c;
            flags      <= flags_c;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=16: stimulus pushes hand-computed
// expectations, a monitor pops and compares on every done pulse.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_in = OP_ADD;
  logic [15:0] s1_in = '0;
  logic [15:0] s2_in = '0;
  logic        busy, done;
  logic [15:0] result_out;
  logic [3:0]  flags;

  alu_mc #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_in      (op_in),
    .s1_in      (s1_in),
    .s2_in      (s2_in),
    .busy       (busy),
    .done       (done),
    .result_out (result_out),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".result"}, 32'(result_out), 32'(e.r));
          chk({e.name, ".flags"},  32'(flags),      32'(e.f));
          chk({e.name, ".cycle"},  32'(cyc),        32'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge; drives start for one sampling edge, then scrambles operands.
  task automatic issue(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef,
                       input bit expect_done);
    exp_t e;
    int   lat;
    lat   = (op == OP_MUL || op == OP_DIVU || op == OP_REMU) ? 17 : 1;
    op_in = op;
    s1_in = a;
    s2_in = b;
    start = 1'b1;
    if (expect_done) begin
      e.name = name;
      e.r    = er;
      e.f    = ef;
      e.cyc  = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_in = OP_RSVD;
    s1_in = 16'hA5A5;
    s2_in = 16'h5A5A;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    issue(name, op, a, b, er, ef, 1'b1);
    wait_empty(name);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset.busy",   32'(busy),       0);
    chk("reset.done",   32'(done),       0);
    chk("reset.result", 32'(result_out), 0);
    chk("reset.flags",  32'(flags),      0);
    rst = 1'b0;
    @(negedge clk);

    // flags are {N,Z,V,C}
    run("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
    run("add_carry", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
    run("cmp",       OP_CMP,  16'h0003, 16'h0005, 16'hFFFE, 4'b1001);
    run("dec_zero",  OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 4'b1001);
    run("sar",       OP_SAR,  16'h8001, 16'h0001, 16'hC000, 4'b1001);
    run("shl4",      OP_SHL,  16'h1001, 16'h0004, 16'h0010, 4'b0001);
    run("shr0",      OP_SHR,  16'h0003, 16'h0000, 16'h0003, 4'b0000);
    run("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0010);
    run("inc_ovf",   OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 4'b1010);
    run("xor",       OP_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000);
    run("not",       OP_NOT,  16'h0000, 16'h1111, 16'hFFFF, 4'b1000);
    run("rsvd",      OP_RSVD, 16'h1234, 16'h5678, 16'h0000, 4'b0100);
    run("mul_hi",    OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b0101);
    run("mul",       OP_MUL,  16'h0012, 16'h0034, 16'h03A8, 4'b0000);
    run("divu",      OP_DIVU, 16'h0064, 16'h0007, 16'h000E, 4'b0000);
    run("remu",      OP_REMU, 16'h0064, 16'h0007, 16'h0002, 4'b0000);
    run("divu_z",    OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 4'b1010);
    run("remu_z",    OP_REMU, 16'h1234, 16'h0000, 16'h1234, 4'b0010);

    // start while busy is ignored
    issue("mul_busy", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b1);
    repeat (4) @(negedge clk);
    chk("ignore.busy", 32'(busy), 1);
    issue("ignored_add", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0);
    wait_empty("mul_busy");

    // start in the done cycle is accepted
    issue("b2b_add", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1'b1);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.done_seen", 32'(done), 1);
    chk("b2b.busy_in_done", 32'(busy), 0);
    issue("b2b_sub", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1001, 1'b1);
    wait_empty("b2b_sub");

    // reset mid-divide abandons it
    issue("divu_abort", OP_DIVU, 16'h0064, 16'h0007, 16'h000E, 4'b0000, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort.busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy",   32'(busy),       0);
    chk("abort.done",   32'(done),       0);
    chk("abort.result", 32'(result_out), 0);
    chk("abort.flags",  32'(flags),      0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort.idle", 32'(busy), 0);
    run("add_after", OP_ADD, 16'h0010, 16'h0020, 16'h0030, 4'b0000);

    chk("sb.empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the CPU's 16-bit combinational ALU.
- Adds shifts and iterative unsigned multiply, divide and remainder behind a start/busy/done handshake.
- Result and the N Z V C flags are registered and update only on completion.
- Sits between the register-file read ports and the writeback/flag register; the control unit stalls while busy=1.

Parameters:
- WIDTH, 16, operand/result width (>=4, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- op_in  in  4  opcode, latched on accept.
- s1_in  in  WIDTH  operand A, latched on accept.
- s2_in  in  WIDTH  operand B, latched on accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result_out/flags valid from this cycle.
- result_out  out  WIDTH  registered result; held until next done.
- flags  out  4  registered [3]=N [2]=Z [1]=V [0]=C; held until next done.

Behaviour:
- Reset: busy=0, done=0, result_out=0, flags=0, FSM=IDLE. Applies mid-operation: the operation is abandoned with no done.
- FSM states: IDLE, EXEC, DONE.
  - IDLE + start: latch operands. Single-cycle op -> DONE. MUL/DIVU/REMU -> EXEC with count=0.
  - EXEC: one iteration per cycle; after WIDTH iterations -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start seen while in DONE is accepted (busy=0 in DONE).
  - start while busy=1 is ignored.
- busy=1 in EXEC, and in the cycle after accept for single-cycle ops.
- Latency, start at edge t: single-cycle op -> done at t+1. Iterative op -> done at t+WIDTH+1.
- Opcodes, results:
  - 0 ADD a+b; 1 SUB a-b; 2 INC a+1; 3 DEC a-1.
  - 4 AND, 5 OR, 6 XOR, 7 NOT a.
  - 8 CMP: a-b; writes both result and flags.
  - 9 SHL: a<<b[SHW-1:0]; A SHR logical; B SAR arithmetic.
  - C MUL: low WIDTH bits of unsigned a*b (shift-add).
  - D DIVU: quotient a/b (restoring); E REMU: remainder a%b.
  - F: reserved; result 0, flags 0000 except Z=1.
- Carry is bit WIDTH of a WIDTH+1-bit zero-extended computation:
  - ADD/INC: carry out. SUB/CMP/DEC: borrow, i.e. C=1 iff a<b, or a==0 for DEC.
  - Shifts: C = last bit shifted out; C=0 when the amount is 0.
  - MUL: C=1 iff the upper WIDTH bits of the product are nonzero.
  - Logic ops, DIVU, REMU: C=0.
- V (overflow):
  - ADD: sign(a)==sign(b) and sign(r)!=sign(a).
  - SUB/CMP: sign(a)!=sign(b) and sign(r)!=sign(a).
  - INC: a==0111..1. DEC: a==1000..0.
  - DIVU/REMU with b==0: V=1; quotient = all ones, remainder = a; still takes WIDTH+1 cycles.
  - All other ops: V=0.
- N = r[WIDTH-1]; Z = (r==0) for every op.
- Operand ports may change freely after accept; they do not affect the running operation.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_REMU, OP_RSVD;
  - flag bit indices FLAG_N/Z/V/C;
  - FSM state encoding;
  - a function is_iterative(op).
- Sub-module alu_muldiv_iter (parametrised by WIDTH) implements the shift-add multiplier and restoring divider. It exposes load/step inputs and product_hi/lo, quotient and remainder outputs. The top FSM owns the counter and the flags.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001 -> done at t+1, result 0x8000, flags N=1 Z=0 V=1 C=0; ADD 0xFFFF+0x0001 -> 0x0000, Z=1 C=1 V=0.
- CMP 0x0003,0x0005 -> result 0xFFFE, N=1 C=1 V=0; DEC 0x0000 -> 0xFFFF, C=1; SAR 0x8001 by 1 -> 0xC000, C=1.
- MUL 0x0100*0x0100 -> done exactly 17 cycles after start, result 0x0000, Z=1 C=1; MUL 0x0012*0x0034 -> 0x03A8, C=0.
- DIVU 0x0064/0x0007 -> 0x000E; REMU same operands -> 0x0002; DIVU 0x1234/0 -> 0xFFFF, V=1; REMU 0x1234/0 -> 0x1234, V=1.
- Start MUL, pulse start with ADD at cycle 5 -> ignored, MUL result delivered. Start the next op in the DONE cycle -> accepted, back-to-back done pulses.
- Assert rst at cycle 8 of DIVU -> next cycle busy=0, result_out=0, flags=0, no done; a new ADD then completes normally.
